// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: owns PC and instruction register,
// shares one valid/ready memory port between fetch and load/store access.
module core_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic [31:0] instr,
    input  logic        dec_mem,
    input  logic        dec_mem_read,
    input  logic        dec_wb,
    input  logic        dec_branch,
    input  logic        dec_uncond,
    input  logic        branch_taken,
    input  logic [31:0] alu_result,
    input  logic [31:0] target,
    input  logic [31:0] rb_data,

    output logic [31:0] pc,
    output logic [31:0] load_data,
    output logic        rf_we,
    output logic [1:0]  rf_wd_sel,
    output logic        retire,
    input  logic        halt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALTED    = 3'd5
    } state_t;

    state_t      cur_state;
    state_t      next_state;
    logic        fetch_armed;
    logic        is_load;
    logic        take_target;
    logic [31:0] pc_next;

    assign is_load     = dec_mem & dec_mem_read;
    assign take_target = dec_branch & (dec_uncond | branch_taken);
    assign pc_next     = (take_target ? target : pc + 32'd4) & 32'hFFFF_FFFC;
    assign state       = cur_state;

    always_comb begin
        next_state = cur_state;
        mem_valid  = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        rf_we      = 1'b0;
        rf_wd_sel  = 2'd0;
        retire     = 1'b0;

        case (cur_state)
            FETCH: begin
                // fetch_armed keeps the port idle in the first cycle out of reset
                mem_valid = fetch_armed;
                mem_addr  = pc;
                if (fetch_armed && mem_ready) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                next_state = EXECUTE;
            end
            EXECUTE: begin
                next_state = dec_mem ? MEM : WRITEBACK;
            end
            MEM: begin
                mem_valid = 1'b1;
                mem_addr  = alu_result;
                mem_we    = ~dec_mem_read;
                mem_wdata = dec_mem_read ? '0 : rb_data;
                if (mem_ready) begin
                    next_state = WRITEBACK;
                end
            end
            WRITEBACK: begin
                retire = 1'b1;
                rf_we  = dec_uncond | dec_wb | is_load;
                if (dec_uncond) begin
                    rf_wd_sel = 2'd2;
                end else if (is_load) begin
                    rf_wd_sel = 2'd1;
                end
                next_state = halt ? HALTED : FETCH;
            end
            HALTED: begin
                if (!halt) begin
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= FETCH;
            fetch_armed <= 1'b0;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            load_data   <= '0;
        end else begin
            cur_state   <= next_state;
            fetch_armed <= 1'b1;
            if (cur_state == FETCH && fetch_armed && mem_ready) begin
                instr <= mem_rdata;
            end
            if (cur_state == MEM && mem_ready && is_load) begin
                load_data <= mem_rdata;
            end
            if (cur_state == WRITEBACK) begin
                pc <= pc_next;
            end
        end
    end

endmodule
